// File: rtl/lcd_char_writer_pkg.sv
// Shared definitions for the LCD character writer: FSM encodings,
// counter width and the HD44780 command bytes sent during configuration.
package lcd_char_writer_pkg;

    // Wide enough for the power-on wait (750000 cycles at 50 MHz).
    localparam int CNT_W = 20;

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_INIT0,
        ST_INIT1,
        ST_INIT2,
        ST_INIT3,
        ST_CFG,
        ST_IDLE,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_ADDR
    } lcd_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_HOLD,
        TX_WAIT
    } tx_state_t;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    // Configuration command bytes in the order they are sent.
    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_ENTRY;
            2'd2:    return LCD_DISP_ON;
            default: return LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_char_writer_nibble_tx.sv
// lcd_nibble_tx: one 4-bit write to the LCD.
// SETUP (2 cycles, counting the start cycle) -> PULSE (P_PULSE cycles, E=1)
// -> HOLD (1 cycle) -> WAIT (wait_len cycles). done is high on the last
// WAIT cycle so the caller can launch the next write back-to-back.
// The caller holds nibble/rs stable from the start pulse until done.
module lcd_nibble_tx
    import lcd_char_writer_pkg::*;
#(
    parameter int P_PULSE = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       nibble,
    input  logic             rs,
    input  logic [CNT_W-1:0] wait_len,
    output logic             lcd_e,
    output logic [3:0]       lcd_data,
    output logic             lcd_rs,
    output logic             done
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(P_PULSE - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wait_q;

    // Bus lines come straight from the caller's held registers, so data is
    // valid from the very cycle the start pulse is issued.
    assign lcd_data = nibble;
    assign lcd_rs   = rs;

    assign done = (state == TX_WAIT) && (cnt == wait_q - CNT_W'(1));

    // Write timing FSM; E is registered and drops on the reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= TX_IDLE;
            cnt    <= '0;
            wait_q <= '0;
            lcd_e  <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        state  <= TX_SETUP;
                        wait_q <= wait_len;
                        cnt    <= '0;
                    end
                end
                TX_SETUP: begin
                    state <= TX_PULSE;
                    lcd_e <= 1'b1;
                    cnt   <= '0;
                end
                TX_PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        state <= TX_HOLD;
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TX_HOLD: begin
                    state <= TX_WAIT;
                    cnt   <= '0;
                end
                TX_WAIT: begin
                    if (cnt == wait_q - CNT_W'(1)) begin
                        state <= TX_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    lcd_e <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: accepts one character per handshake and writes it to a
// 4-bit HD44780 LCD after running the power-on init and configuration.
// Optional build macro LCD_LINE_WRAP_EN: moves the cursor to line 2 after
// 16 characters and back to line 1 after 32.
module lcd_char_writer
    import lcd_char_writer_pkg::*;
#(
    parameter int P_POWERON   = 750000,
    parameter int P_WAIT_4MS  = 205000,
    parameter int P_WAIT_100US = 5000,
    parameter int P_WAIT_40US = 2000,
    parameter int P_WAIT_1US  = 50,
    parameter int P_WAIT_CLEAR = 82000,
    parameter int P_PULSE     = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iData_Ready,
    output logic       oReadyForData,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_StrataFlashControl,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(P_POWERON - 1);
    localparam logic [CNT_W-1:0] W_4MS    = CNT_W'(P_WAIT_4MS);
    localparam logic [CNT_W-1:0] W_100US  = CNT_W'(P_WAIT_100US);
    localparam logic [CNT_W-1:0] W_40US   = CNT_W'(P_WAIT_40US);
    localparam logic [CNT_W-1:0] W_1US    = CNT_W'(P_WAIT_1US);
    localparam logic [CNT_W-1:0] W_CLEAR  = CNT_W'(P_WAIT_CLEAR);

    lcd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       cfg_idx;     // {byte index, lower-nibble flag}
    logic [3:0]       data_lo;     // low nibble of the accepted character
    logic             tx_start;
    logic [3:0]       tx_nib;
    logic             tx_rs;
    logic [CNT_W-1:0] tx_wait;
    logic             tx_done;
    logic             ready;

`ifdef LCD_LINE_WRAP_EN
    logic [4:0]       char_cnt;
    logic [7:0]       addr_byte;
    logic             addr_lo;
    logic [7:0]       line_cmd;

    // 16th character moves to line 2, the 32nd back to line 1.
    assign line_cmd = (char_cnt == 5'd15) ? LCD_LINE2 : LCD_LINE1;
`endif

    // Nibble of configuration step idx (upper nibble first).
    function automatic logic [3:0] cfg_nib(input logic [2:0] idx);
        logic [7:0] b;
        b = cfg_byte(idx[1+:2]);
        return idx[0] ? b[3:0] : b[7:4];
    endfunction

    // Wait after configuration step idx: short gap between nibbles, long
    // settle after each byte, extra long after Clear Display.
    function automatic logic [CNT_W-1:0] cfg_wait(input logic [2:0] idx);
        if (!idx[0])
            return W_1US;
        else if (idx[1+:2] == 2'd3)
            return W_CLEAR;
        else
            return W_40US;
    endfunction

    assign oReadyForData           = ready;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;

    // Sequencer: each transition that needs a write launches it on the same
    // edge, so back-to-back nibbles have no idle cycle between them.
    // NOTE: non-blocking assignments everywhere here, so every branch reads
    // the pre-edge register values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_PWR_WAIT;
            cnt      <= '0;
            cfg_idx  <= '0;
            data_lo  <= '0;
            tx_start <= 1'b0;
            tx_nib   <= '0;
            tx_rs    <= 1'b0;
            tx_wait  <= '0;
            ready    <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
            char_cnt  <= '0;
            addr_byte <= '0;
            addr_lo   <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            cnt      <= '0;
            case (state)
                ST_PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        state    <= ST_INIT0;
                        tx_start <= 1'b1;
                        tx_nib   <= 4'h3;
                        tx_rs    <= 1'b0;
                        tx_wait  <= W_4MS;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_INIT0: begin
                    if (tx_done) begin
                        state    <= ST_INIT1;
                        tx_start <= 1'b1;
                        tx_nib   <= 4'h3;
                        tx_wait  <= W_100US;
                    end
                end
                ST_INIT1: begin
                    if (tx_done) begin
                        state    <= ST_INIT2;
                        tx_start <= 1'b1;
                        tx_nib   <= 4'h3;
                        tx_wait  <= W_40US;
                    end
                end
                ST_INIT2: begin
                    if (tx_done) begin
                        state    <= ST_INIT3;
                        tx_start <= 1'b1;
                        tx_nib   <= 4'h2;
                        tx_wait  <= W_40US;
                    end
                end
                ST_INIT3: begin
                    if (tx_done) begin
                        state    <= ST_CFG;
                        cfg_idx  <= 3'd0;
                        tx_start <= 1'b1;
                        tx_nib   <= cfg_nib(3'd0);
                        tx_wait  <= cfg_wait(3'd0);
                    end
                end
                ST_CFG: begin
                    if (tx_done) begin
                        if (cfg_idx == 3'd7) begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
`ifdef LCD_LINE_WRAP_EN
                            char_cnt <= '0;
`endif
                        end else begin
                            cfg_idx  <= cfg_idx + 3'd1;
                            tx_start <= 1'b1;
                            tx_nib   <= cfg_nib(cfg_idx + 3'd1);
                            tx_wait  <= cfg_wait(cfg_idx + 3'd1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (iData_Ready) begin
                        state    <= ST_DATA_HI;
                        ready    <= 1'b0;
                        data_lo  <= iData[3:0];
                        tx_start <= 1'b1;
                        tx_nib   <= iData[7:4];
                        tx_rs    <= 1'b1;
                        tx_wait  <= W_1US;
                    end
                end
                ST_DATA_HI: begin
                    if (tx_done) begin
                        state    <= ST_DATA_LO;
                        tx_start <= 1'b1;
                        tx_nib   <= data_lo;
                        tx_wait  <= W_40US;
                    end
                end
                ST_DATA_LO: begin
                    if (tx_done) begin
`ifdef LCD_LINE_WRAP_EN
                        char_cnt <= char_cnt + 5'd1;
                        if (char_cnt == 5'd15 || char_cnt == 5'd31) begin
                            state     <= ST_ADDR;
                            addr_byte <= line_cmd;
                            addr_lo   <= 1'b0;
                            tx_start  <= 1'b1;
                            tx_nib    <= line_cmd[7:4];
                            tx_rs     <= 1'b0;
                            tx_wait   <= W_1US;
                        end else begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                        end
`else
                        state <= ST_IDLE;
                        ready <= 1'b1;
`endif
                    end
                end
`ifdef LCD_LINE_WRAP_EN
                ST_ADDR: begin
                    if (tx_done) begin
                        if (!addr_lo) begin
                            addr_lo  <= 1'b1;
                            tx_start <= 1'b1;
                            tx_nib   <= addr_byte[3:0];
                            tx_wait  <= W_40US;
                        end else begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= ST_PWR_WAIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    lcd_nibble_tx #(
        .P_PULSE (P_PULSE)
    ) u_tx (
        .clk      (Clock),
        .rst      (Reset),
        .start    (tx_start),
        .nibble   (tx_nib),
        .rs       (tx_rs),
        .wait_len (tx_wait),
        .lcd_e    (oLCD_Enabled),
        .lcd_data (oLCD_Data),
        .lcd_rs   (oLCD_RegisterSelect),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_lcd_char_writer.sv
// Testbench for lcd_char_writer with shortened timing parameters.
// A timeline model predicts, for every cycle, E, RS, data and ready from
// the absolute start time of each scheduled nibble write.
module tb_lcd_char_writer;

    localparam int TP_POWERON = 20;
    localparam int TP_4MS     = 10;
    localparam int TP_100US   = 6;
    localparam int TP_40US    = 4;
    localparam int TP_1US     = 2;
    localparam int TP_CLEAR   = 8;
    localparam int TP_PULSE   = 3;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iData = 8'h00;
    logic       iData_Ready = 1'b0;
    logic       oReadyForData;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_StrataFlashControl;
    logic       oLCD_ReadWrite;
    logic [3:0] oLCD_Data;

    lcd_char_writer #(
        .P_POWERON    (TP_POWERON),
        .P_WAIT_4MS   (TP_4MS),
        .P_WAIT_100US (TP_100US),
        .P_WAIT_40US  (TP_40US),
        .P_WAIT_1US   (TP_1US),
        .P_WAIT_CLEAR (TP_CLEAR),
        .P_PULSE      (TP_PULSE)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iData                   (iData),
        .iData_Ready             (iData_Ready),
        .oReadyForData           (oReadyForData),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_Data               (oLCD_Data)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural timeline model ----------------
    typedef struct {
        int       start;
        bit       rs;
        bit [3:0] nib;
        int       wt;
    } wr_t;

    wr_t      sched[$];
    bit [7:0] m_acc[$];
    bit       started  = 1'b0;
    bit       m_ready  = 1'b0;
    int       ready_at = -1;
    int       rst_cyc  = -1;
    int       m_chars  = 0;

    // A nibble write launched at edge t occupies 2 setup + P pulse + 1 hold + w wait cycles.
    function automatic int push_nib(int t, bit rs, bit [3:0] n, int w);
        wr_t e;
        e.start = t; e.rs = rs; e.nib = n; e.wt = w;
        sched.push_back(e);
        return t + 3 + TP_PULSE + w;
    endfunction

    function automatic int push_byte(int t, bit rs, bit [7:0] b, int w_lo);
        int tt;
        tt = push_nib(t, rs, b[7:4], TP_1US);
        return push_nib(tt, rs, b[3:0], w_lo);
    endfunction

    always @(posedge Clock) begin
        int t;
        cyc++;
        if (Reset) begin
            started = 1'b1;
            rst_cyc = cyc;
            sched.delete();
            m_ready = 1'b0;
            m_chars = 0;
            t = cyc + TP_POWERON;
            t = push_nib(t, 1'b0, 4'h3, TP_4MS);
            t = push_nib(t, 1'b0, 4'h3, TP_100US);
            t = push_nib(t, 1'b0, 4'h3, TP_40US);
            t = push_nib(t, 1'b0, 4'h2, TP_40US);
            t = push_byte(t, 1'b0, 8'h28, TP_40US);
            t = push_byte(t, 1'b0, 8'h06, TP_40US);
            t = push_byte(t, 1'b0, 8'h0C, TP_40US);
            t = push_byte(t, 1'b0, 8'h01, TP_CLEAR);
            ready_at = t;
        end else if (started) begin
            if (m_ready && iData_Ready === 1'b1) begin
                m_ready = 1'b0;
                m_acc.push_back(iData);
                t = push_byte(cyc, 1'b1, iData, TP_40US);
`ifdef LCD_LINE_WRAP_EN
                m_chars = (m_chars + 1) % 32;
                if (m_chars == 16)
                    t = push_byte(t, 1'b0, 8'hC0, TP_40US);
                else if (m_chars == 0)
                    t = push_byte(t, 1'b0, 8'h80, TP_40US);
`endif
                ready_at = t;
            end
            if (!m_ready && cyc == ready_at)
                m_ready = 1'b1;
        end
    end

    // ---------------- per-cycle compare and pulse log ----------------
    bit [4:0] log_q[$];
    logic     prev_e = 1'b0;
    int       e_cnt  = 0;

    always @(negedge Clock) begin
        wr_t w;
        bit  have_w;
        bit  exp_e;
        if (started) begin
            while (sched.size() > 0 && sched[0].start + 3 + TP_PULSE + sched[0].wt <= cyc)
                void'(sched.pop_front());
            have_w = 1'b0;
            if (sched.size() > 0 && sched[0].start <= cyc) begin
                have_w = 1'b1;
                w = sched[0];
            end
            exp_e = have_w && cyc >= w.start + 2 && cyc < w.start + 2 + TP_PULSE;
            check("E", {31'd0, oLCD_Enabled}, {31'd0, exp_e});
            check("ready", {31'd0, oReadyForData}, {31'd0, m_ready});
            check("strataflash", {31'd0, oLCD_StrataFlashControl}, 32'd1);
            check("rw", {31'd0, oLCD_ReadWrite}, 32'd0);
            if (have_w && cyc < w.start + 3 + TP_PULSE) begin
                check("data", {28'd0, oLCD_Data}, {28'd0, w.nib});
                check("rs", {31'd0, oLCD_RegisterSelect}, {31'd0, w.rs});
            end
            if (oLCD_Enabled === 1'b1) begin
                if (prev_e !== 1'b1)
                    log_q.push_back({oLCD_RegisterSelect, oLCD_Data});
                e_cnt++;
            end else if (prev_e === 1'b1) begin
                if (rst_cyc != cyc)
                    check("E width", e_cnt, TP_PULSE);
                e_cnt = 0;
            end
            prev_e = oLCD_Enabled;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input int budget, input string name);
        int n = 0;
        while (oReadyForData !== 1'b1 && n < budget) begin
            @(negedge Clock);
            n++;
        end
        check(name, {31'd0, oReadyForData}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        iData       = b;
        iData_Ready = 1'b1;
        @(negedge Clock);
        iData_Ready = 1'b0;
    endtask

    task automatic check_init_log(input string name);
        bit [4:0] init_exp[12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                   5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
        check({name, " count"}, log_q.size(), 12);
        for (int i = 0; i < 12 && i < log_q.size(); i++)
            check(name, {27'd0, log_q[i]}, {27'd0, init_exp[i]});
    endtask

    initial begin
        int c0;
        int n;
        bit [7:0] got[$];
        bit [4:0] exp_q[$];

        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int       c0;
        int       n;
        bit [7:0] got[$];
        bit [4:0] exp_q[$];

        // Reset state
        repeat (3) @(negedge Clock);
        check("rst E", {31'd0, oLCD_Enabled}, 32'd0);
        check("rst RS", {31'd0, oLCD_RegisterSelect}, 32'd0);
        check("rst data", {28'd0, oLCD_Data}, 32'd0);
        check("rst ready", {31'd0, oReadyForData}, 32'd0);
        log_q.delete();
        Reset = 1'b0;

        // Power-on init and configuration
        wait_ready(400, "init ready timeout");
        check_init_log("init nibble");

        // Single character 0x41
        log_q.delete();
        c0 = cyc;
        send_byte(8'h41);
        check("ready drop", {31'd0, oReadyForData}, 32'd0);
        wait_ready(100, "0x41 ready timeout");
        check("latency", cyc - (c0 + 1), 18);
        check("0x41 count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("0x41 hi", {27'd0, log_q[0]}, 32'h14);
            check("0x41 lo", {27'd0, log_q[1]}, 32'h11);
        end

        // Handshake during a transfer is ignored
        log_q.delete();
        send_byte(8'h10);
        repeat (4) @(negedge Clock);
        send_byte(8'h55);
        iData = 8'h00;
        wait_ready(100, "0x55 ready timeout");
        check("ignored count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("0x10 hi", {27'd0, log_q[0]}, 32'h11);
            check("0x10 lo", {27'd0, log_q[1]}, 32'h10);
        end

        // Ready held high: three bytes back to back
        log_q.delete();
        iData_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iData = 8'h30 + 8'(i);
            wait_ready(100, "held ready timeout");
            @(negedge Clock);
        end
        iData_Ready = 1'b0;
        iData = 8'hFF;
        wait_ready(100, "held end timeout");
        exp_q = '{5'h13, 5'h10, 5'h13, 5'h11, 5'h13, 5'h12};
        check("held count", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            check("held nibble", {27'd0, log_q[i]}, {27'd0, exp_q[i]});

        // Randomised traffic with ignored strobes mid-transfer
        log_q.delete();
        m_acc.delete();
        for (int i = 0; i < 20; i++) begin
            wait_ready(200, "rand ready timeout");
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            send_byte(8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 10)) @(negedge Clock);
                send_byte(8'($urandom));
            end
        end
        wait_ready(200, "rand end timeout");
        got.delete();
        n = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i][4]) begin
                n++;
                if (i + 1 < log_q.size() && log_q[i + 1][4]) begin
                    got.push_back({log_q[i][3:0], log_q[i + 1][3:0]});
                    n++;
                    i++;
                end
            end
        end
        check("rand data nibbles", n, 40);
        check("rand accepted", m_acc.size(), 20);
        for (int i = 0; i < got.size() && i < m_acc.size(); i++)
            check("rand byte", {24'd0, got[i]}, {24'd0, m_acc[i]});

        // Reset during the upper-nibble enable pulse
        send_byte(8'hA7);
        n = 0;
        while (!(oLCD_Enabled === 1'b1 && oLCD_RegisterSelect === 1'b1) && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("pulse seen", {31'd0, oLCD_Enabled & oLCD_RegisterSelect}, 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        check("reset E drop", {31'd0, oLCD_Enabled}, 32'd0);
        @(negedge Clock);
        log_q.delete();
        Reset = 1'b0;
        wait_ready(400, "reinit ready timeout");
        check_init_log("reinit nibble");

`ifdef LCD_LINE_WRAP_EN
        // Line wrap: 33 characters after a fresh init
        log_q.delete();
        exp_q.delete();
        for (int i = 0; i < 33; i++) begin
            logic [7:0] b;
            b = 8'h40 + 8'(i);
            wait_ready(200, "wrap ready timeout");
            send_byte(b);
            exp_q.push_back({1'b1, b[7:4]});
            exp_q.push_back({1'b1, b[3:0]});
            if (i == 15) begin
                exp_q.push_back(5'h0C);
                exp_q.push_back(5'h00);
            end
            if (i == 31) begin
                exp_q.push_back(5'h08);
                exp_q.push_back(5'h00);
            end
        end
        wait_ready(200, "wrap end timeout");
        check("wrap count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check("wrap nibble", {27'd0, log_q[i]}, {27'd0, exp_q[i]});
`endif

        repeat (2) @(negedge Clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
